sram_fetch_arbiter: RTL

//  Sole owner of the base SRAM. Serves instruction fetches for the IF stage and

---
 rtl/sram_fetch_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sram_fetch_arbiter.sv
// Shares one asynchronous SRAM port between IF fetches and MEM loads/stores, MEM first.
// Optional SRAM_ADDR_CHECK_EN: requests outside addr[31:22]==10'h200 skip the SRAM and flag addr_err.
module sram_fetch_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic              addr_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;  // 1 = MEM owns the transaction
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [31:0]         dq_o_q, dq_o_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [3:0]          be_n_q, be_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                err_q, err_d;

  logic [31:0]         acc_addr;
  logic                acc_we;
  logic                unused_addr_bits;

  assign acc_addr         = mem_req ? mem_addr : if_addr;
  assign acc_we           = mem_req & mem_we;
  assign unused_addr_bits = ^acc_addr;

  // Next-state, latched request copies and registered strobe values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    be_d        = be_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
          owner_d = mem_req;
`ifdef SRAM_ADDR_CHECK_EN
          if (acc_addr[31:22] != 10'h200) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (!acc_we) begin
              if (mem_req) mem_rdata_d = 32'h0;
              else         if_rdata_d  = 32'h0;
            end
          end else
`endif
          begin
            sram_addr_d = acc_addr[ADDR_W+1:2];
            cnt_d       = CNT_W'(WAIT_CYCLES);
            if (acc_we) begin
              state_d = WR;
              be_d    = mem_be;
              dq_o_d  = mem_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = DONE;
          if (owner_q) mem_rdata_d = sram_dq_i;
          else         if_rdata_d  = sram_dq_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR: begin
        if (cnt_q == CNT_W'(0)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ce_n_d    = !((state_d == RD) || (state_d == WR));
    oe_n_d    = (state_d != RD);
    we_n_d    = (state_d != WR);
    be_n_d    = (state_d == RD) ? 4'h0 : ((state_d == WR) ? ~be_d : 4'hF);
    dq_oe_d   = (state_d == WR) || ((state_q == WR) && (state_d == DONE));
    if_ack_d  = (state_d == DONE) && !owner_d;
    mem_ack_d = (state_d == DONE) && owner_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      be_q        <= 4'h0;
      sram_addr_q <= '0;
      dq_o_q      <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      dq_oe_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      be_q        <= be_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign if_stall   = if_req & ~if_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;
`ifdef SRAM_ADDR_CHECK_EN
  assign addr_err   = err_q;
`else
  assign addr_err   = 1'b0;
`endif

endmodule
